// File: rtl/zigzag_encryption.sv
// Rail-fence (zigzag) encryptor: buffers plaintext bytes until the start token,
// then streams the ciphertext one byte per cycle using 1, 2 or 3 rails.
module zigzag_encryption #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 KEY_WIDTH              = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = 'hFA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o
);

  localparam int A_W = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
  localparam int N_W = $clog2(MAX_NOF_CHARS + 1);
  // Index must hold one full step past the last character before the rail wraps.
  localparam int I_W = $clog2(MAX_NOF_CHARS + 4);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t             state;
  logic [N_W-1:0]     n;
  logic [N_W-1:0]     cnt;
  logic [I_W-1:0]     idx;
  logic [1:0]         rails;
  logic [1:0]         rail;
  logic [D_WIDTH-1:0] buf_mem [MAX_NOF_CHARS];

  logic               is_token;
  logic               store;
  logic [1:0]         key_rails;
  logic [I_W-1:0]     step;
  logic [I_W-1:0]     idx_step;
  logic [I_W-1:0]     idx_next;
  logic [1:0]         rail_next;

  assign is_token = (data_i == START_ENCRYPTION_TOKEN);
  assign store    = (state == COLLECT) && valid_i && !is_token
                    && (n < N_W'(MAX_NOF_CHARS));

  always_comb begin
    if (key <= KEY_WIDTH'(1))      key_rails = 2'd1;
    else if (key == KEY_WIDTH'(2)) key_rails = 2'd2;
    else                           key_rails = 2'd3;
  end

  // Per-rail stride: rails 0 and 2 of a 3-rail fence visit every fourth index.
  always_comb begin
    step = I_W'(1);
    if (rails == 2'd2)                      step = I_W'(2);
    else if (rails == 2'd3 && rail == 2'd1) step = I_W'(2);
    else if (rails == 2'd3)                 step = I_W'(4);

    idx_step  = idx + step;
    idx_next  = idx_step;
    rail_next = rail;
    // Rail r starts at index r; rails with no index < n only occur after the
    // last byte, so the emitted-count check ends the message before reaching one.
    if (idx_step >= I_W'(n)) begin
      rail_next = rail + 2'd1;
      idx_next  = I_W'(rail_next);
    end
  end

  // NOTE: the character buffer is deliberately left out of reset; only n decides
  // which entries are meaningful, and resetting a memory array blocks RAM mapping.
  always_ff @(posedge clk) begin
    if (store) buf_mem[A_W'(n)] <= data_i;
  end

  // NOTE: all state updates here use non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= COLLECT;
      n       <= '0;
      cnt     <= '0;
      idx     <= '0;
      rails   <= 2'd1;
      rail    <= '0;
      busy    <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      case (state)
        COLLECT: begin
          valid_o <= 1'b0;
          data_o  <= '0;
          if (store) begin
            n <= n + N_W'(1);
          end else if (valid_i && is_token && n != '0) begin
            state <= EMIT;
            busy  <= 1'b1;
            rails <= key_rails;
            rail  <= '0;
            idx   <= '0;
            cnt   <= '0;
          end
        end
        EMIT: begin
          if (cnt == n) begin
            state   <= COLLECT;
            busy    <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= '0;
            n       <= '0;
          end else begin
            valid_o <= 1'b1;
            data_o  <= buf_mem[A_W'(idx)];
            cnt     <= cnt + N_W'(1);
            idx     <= idx_next;
            rail    <= rail_next;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_zigzag_encryption.sv
// Directed bench for zigzag_encryption: table of hand-encrypted messages plus
// sequences for empty token, buffer overflow, ignored input while busy and reset abort.
module tb_zigzag_encryption;

  localparam logic [7:0] TOKEN = 8'hFA;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] key;
  logic       busy;
  logic [7:0] data_o;
  logic       valid_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] msg  [64];
  logic [7:0] expb [64];

  typedef struct {
    logic [7:0]  key;
    int          len;
    logic [79:0] pt;
    logic [79:0] ct;
  } vec_t;

  vec_t vecs [11];

  zigzag_encryption dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key     (key),
    .busy    (busy),
    .data_o  (data_o),
    .valid_o (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = b;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  // Sends msg[0..len-1] then the token; checks the busy-only cycle, every output
  // byte against expb, and the idle cycle after. noise drives junk while busy;
  // abort_at >= 0 pulses reset on the edge that would emit byte abort_at.
  task automatic run_case(input string name, input int len, input logic [7:0] k,
                          input bit noise, input int abort_at);
    key = k;
    for (int i = 0; i < len; i++) send_byte(msg[i]);
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = TOKEN;
    @(posedge clk);
    #1;
    check({name, " busy after token"}, 32'(busy), 32'd1);
    check({name, " valid after token"}, 32'(valid_o), 32'd0);
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      if (noise) begin
        valid_i = 1'b1;
        data_i  = j[0] ? TOKEN : 8'h5A;
        key     = 8'($urandom_range(0, 255));
      end else begin
        valid_i = 1'b0;
      end
      if (j == abort_at) rst_n = 1'b0;
      @(posedge clk);
      #1;
      if (j == abort_at) begin
        check({name, " abort busy"}, 32'(busy), 32'd0);
        check({name, " abort valid"}, 32'(valid_o), 32'd0);
        check({name, " abort data"}, 32'(data_o), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        valid_i = 1'b0;
        return;
      end
      check($sformatf("%s valid[%0d]", name, j), 32'(valid_o), 32'd1);
      check($sformatf("%s busy[%0d]", name, j), 32'(busy), 32'd1);
      check($sformatf("%s data[%0d]", name, j), 32'(data_o), 32'(expb[j]));
    end
    @(negedge clk);
    if (noise) begin
      valid_i = 1'b1;
      data_i  = 8'h5A;
    end else begin
      valid_i = 1'b0;
    end
    @(posedge clk);
    #1;
    check({name, " end busy"}, 32'(busy), 32'd0);
    check({name, " end valid"}, 32'(valid_o), 32'd0);
    check({name, " end data"}, 32'(data_o), 32'd0);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{8'd2,   7,  80'("ABCDEFG"),    80'("ACEGBDF")};
    vecs[1]  = '{8'd3,   7,  80'("ABCDEFG"),    80'("AEBDFCG")};
    vecs[2]  = '{8'd9,   7,  80'("ABCDEFG"),    80'("AEBDFCG")};
    vecs[3]  = '{8'd1,   7,  80'("ABCDEFG"),    80'("ABCDEFG")};
    vecs[4]  = '{8'd0,   7,  80'("ABCDEFG"),    80'("ABCDEFG")};
    vecs[5]  = '{8'd3,   2,  80'("AB"),         80'("AB")};
    vecs[6]  = '{8'd3,   10, 80'("HELLOWORLD"), 80'("HOLELWRDLO")};
    vecs[7]  = '{8'd2,   10, 80'("HELLOWORLD"), 80'("HLOOLELWRD")};
    vecs[8]  = '{8'd3,   1,  80'("Z"),          80'("Z")};
    vecs[9]  = '{8'd3,   5,  80'("ABCDE"),      80'("AEBDC")};
    vecs[10] = '{8'd255, 3,  80'("ABC"),        80'("ABC")};

    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = 8'h00;
    key     = 8'd0;
    repeat (5) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(valid_o), 32'd0);
    check("reset data", 32'(data_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Token with an empty buffer is ignored.
    key = 8'd3;
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = TOKEN;
    @(negedge clk);
    valid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("empty busy[%0d]", c), 32'(busy), 32'd0);
      check($sformatf("empty valid[%0d]", c), 32'(valid_o), 32'd0);
    end

    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < vecs[v].len; i++) begin
        msg[i]  = vecs[v].pt[8*(vecs[v].len-1-i) +: 8];
        expb[i] = vecs[v].ct[8*(vecs[v].len-1-i) +: 8];
      end
      run_case($sformatf("vec%0d", v), vecs[v].len, vecs[v].key, 1'b0, -1);
    end

    // Overflow: 52 bytes offered, only the first 50 are kept.
    for (int i = 0; i < 52; i++) msg[i] = 8'(i);
    for (int i = 0; i < 25; i++) begin
      expb[i]      = 8'(2 * i);
      expb[25 + i] = 8'(2 * i + 1);
    end
    key = 8'd2;
    for (int i = 0; i < 52; i++) send_byte(msg[i]);
    run_case("overflow", 50, 8'd2, 1'b0, -1);

    // Junk on the inputs while busy must not disturb the message.
    msg[0] = "A"; msg[1] = "B"; msg[2] = "C"; msg[3] = "D"; msg[4] = "E";
    expb[0] = "A"; expb[1] = "E"; expb[2] = "B"; expb[3] = "D"; expb[4] = "C";
    run_case("noise", 5, 8'd3, 1'b1, -1);
    expb[0] = "A"; expb[1] = "C"; expb[2] = "E"; expb[3] = "B"; expb[4] = "D";
    run_case("after_noise", 5, 8'd2, 1'b0, -1);

    // Reset during the third output byte, then a fresh message.
    for (int i = 0; i < 7; i++) msg[i] = 8'h41 + 8'(i);
    expb[0] = "A"; expb[1] = "C"; expb[2] = "E";
    run_case("abort", 7, 8'd2, 1'b0, 2);
    msg[0] = "X"; msg[1] = "Y";
    expb[0] = "X"; expb[1] = "Y";
    run_case("after_abort", 2, 8'd2, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
